// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder and the memory stage.
package dmem_responder_pkg;

    localparam int DMEM_DEPTH_WORDS = 1024;
    localparam int DMEM_LATENCY     = 1;
    localparam int DMEM_ADDR_W      = 32;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic [3:0]             be;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous byte-enabled write, combinational word read.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       be_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed response
// latency, response held until the pipeline accepts it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int LATENCY     = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int         WIDX_W   = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    dmem_resp_t        resp_q, resp_d;
    logic [WIDX_W-1:0] word_idx;
    logic              in_range;
    logic              accept;
    logic              arr_we;
    logic [31:0]       arr_rdata;
    logic              unused_addr_lsbs;

    assign word_idx         = req_addr[ADDR_W-1:2];
    assign unused_addr_lsbs = ^req_addr[1:0];
    assign in_range         = word_idx < WIDX_W'(DEPTH_WORDS);

    // A request seen together with rst is refused, including its array write.
    assign accept = (state_q == ST_IDLE) && req_valid && !rst;
    assign arr_we = accept && req_we && in_range;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i  (clk),
        .we_i   (arr_we),
        .idx_i  (word_idx[IDX_W-1:0]),
        .wdata_i(req_wdata),
        .be_i   (req_be),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = resp_q.rdata;
        resp_err   = resp_q.err;
    end

    // Response is captured at acceptance so it stays stable through WAIT and RESP.
    always_comb begin
        resp_d.err   = !in_range;
        resp_d.rdata = (!req_we && in_range) ? arr_rdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= '0;
        end else if (accept) begin
            resp_q <= resp_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=1 and one LATENCY=3 instance
// share the request bus; sel chooses which instance is driven and observed.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        rv1, rv3, rr1, rr3, err1, err3, busy1, busy3;
    logic [31:0] rd1, rd3;
    logic        resp_valid, req_ready, resp_err, busy;
    logic [31:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv1), .resp_ready(resp_ready & ~sel), .resp_rdata(rd1),
        .resp_err(err1), .busy(busy1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv3), .resp_ready(resp_ready & sel), .resp_rdata(rd3),
        .resp_err(err3), .busy(busy3)
    );

    assign resp_valid = sel ? rv3  : rv1;
    assign req_ready  = sel ? rr3  : rr1;
    assign resp_rdata = sel ? rd3  : rd1;
    assign resp_err   = sel ? err3 : err1;
    assign busy       = sel ? busy3 : busy1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the responder idle again.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic er,
                          output int lat);
        int w = 0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_valid_wait", {31'b0, resp_valid}, 32'd1);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc_cyc [8];
        logic [31:0] rsp [8];
        int          idx, ridx, cyc;

        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
            chk("rst_rdata", resp_rdata, 32'd0);
            chk("rst_err", {31'b0, resp_err}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        end
        sel = 1'b0;
        @(negedge clk);

        // LATENCY=1 basic store/load
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("st_lat", lat, 32'd1);
        chk("st_err", {31'b0, er}, 32'd0);
        chk("st_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("ld_lat", lat, 32'd1);
        chk("ld_rdata", rd, 32'hDEADBEEF);
        chk("ld_idle_ready", {31'b0, req_ready}, 32'd1);

        // Byte enables
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("be_0101", rd, 32'h11BB33DD);
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk("be_0000_err", {31'b0, er}, 32'd0);
        do_req(1'b0, 32'h23, 32'h0, 4'h0, rd, er, lat);
        chk("be_0000_keep", rd, 32'h11BB33DD);

        // Out of range
        do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        chk("oor_ld_err", {31'b0, er}, 32'd1);
        chk("oor_ld_rdata", rd, 32'd0);
        do_req(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
        chk("oor_st_err", {31'b0, er}, 32'd1);
        chk("oor_st_rdata", rd, 32'd0);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("oor_word0", rd, 32'hCAFEF00D);
        chk("inr_err", {31'b0, er}, 32'd0);

        // LATENCY=3 with backpressure
        sel = 1'b1;
        @(negedge clk);
        do_req(1'b1, 32'h20, 32'h0BADC0DE, 4'hF, rd, er, lat);
        chk("l3_st_lat", lat, 32'd3);
        chk("bp_ready0", {31'b0, req_ready}, 32'd1);
        req_we = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_lat", lat, 32'd3);
        chk("bp_rdata0", resp_rdata, 32'h0BADC0DE);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata, 32'h0BADC0DE);
            chk("bp_err", {31'b0, resp_err}, 32'd0);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_busy", {31'b0, busy}, 32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_release_valid", {31'b0, resp_valid}, 32'd0);
        chk("bp_release_busy", {31'b0, busy}, 32'd0);

        // Reset mid-operation
        do_req(1'b1, 32'h14, 32'h00001111, 4'hF, rd, er, lat);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        req_addr = 32'h14; req_wdata = 32'h77;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid_never_valid", {31'b0, resp_valid}, 32'd0);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("mid_store_kept", rd, 32'h00000055);
        do_req(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
        chk("rst_req_refused", rd, 32'h00001111);

        // Back-to-back, req_valid held high
        idx = 0; ridx = 0; cyc = 0;
        resp_ready = 1'b1;
        while (ridx < 8 && cyc < 200) begin
            if (resp_valid) begin
                rsp[ridx] = resp_rdata;
                ridx++;
            end
            if (req_ready && idx < 8) begin
                req_valid = 1'b1;
                req_we    = (idx % 2 == 0);
                req_addr  = 32'h40 + 32'(4 * (idx / 2));
                req_wdata = 32'hA5000000 + 32'(idx);
                req_be    = 4'hF;
                acc_cyc[idx] = cyc;
                idx++;
            end else if (idx >= 8) begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        chk("b2b_resp_count", ridx, 32'd8);
        for (int i = 1; i < 8; i++) begin
            chk("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 32'd4);
        end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) chk("b2b_load", rsp[i], 32'hA5000000 + 32'(i - 1));
            else            chk("b2b_store", rsp[i], 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the memory stage's load/store interface.
- Accepts one request at a time over a valid/ready channel and applies byte-enabled writes or word reads to an internal word array.
- Returns a response after a fixed, parameterised latency and holds it until the pipeline accepts it.
- Lets the memory stage model a real, multi-cycle data memory instead of an inline array.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array.
ADDR_W, 32, request byte-address width.
LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2]; bits [1:0] ignored.
req_wdata  input  32  store data, lane-aligned.
req_be  input  4  byte enables; bit i writes bits [8i+7:8i].
resp_valid  output  1  response present.
resp_ready  input  1  pipeline accepts response.
resp_rdata  output  32  load data; 0 for stores and errors.
resp_err  output  1  word index >= DEPTH_WORDS.
busy  output  1  request outstanding (state != IDLE); drives memory-stage stall.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state = IDLE, latency counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, req_ready = 1 on the first cycle after reset.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. If req_valid, the request is accepted at that edge (cycle T):
    - In range, store: write the enabled bytes at the acceptance edge. be=0000 is a legal no-op.
    - In range, load: capture the addressed word into the response register at the acceptance edge.
    - Out of range: no array access; capture err=1, rdata=0.
    - Next state is RESP if LATENCY==1, else WAIT with counter = LATENCY-1.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 1. req_ready = 0.
  - RESP: resp_valid = 1; rdata and err stable. On resp_ready, go to IDLE the next cycle. While resp_ready = 0, hold every response output unchanged indefinitely. req_ready = 0.
- Latency and throughput:
  - resp_valid first asserts at T+LATENCY.
  - At most one request outstanding; maximum throughput is one request per LATENCY+1 cycles.
  - req_ready depends only on state, never combinationally on resp_ready or req_valid.
- Ordering: a store commits at acceptance, so a load accepted afterwards always returns post-store data.
- Store response: resp_rdata = 0, resp_err per range check.
- Reset mid-operation:
  - A pending response is discarded; resp_valid drops the cycle after reset.
  - A store already accepted stays committed.
  - A request presented in the same cycle as rst=1 is not accepted.
- req_* inputs are sampled only when accepted; values in other cycles are don't-care.

Decomposition:
- constants_pkg gets DMEM_DEPTH_WORDS and DMEM_LATENCY defaults.
- instruction_pkg (shared with the memory stage) gets:
  - dmem_req_t {we, addr, wdata, be}
  - dmem_resp_t {rdata, err}
- Top-level ports may be flattened from these structs.
- One sub-module, dmem_array: single-port synchronous-write RAM with byte enables and combinational word read, DEPTH_WORDS x 32.
- The FSM, counter and response register stay in dmem_responder.

Test Plan:
- LATENCY=1: store addr 0x10, wdata 0xDEADBEEF, be 1111 accepted at T → resp_valid at T+1, err 0, rdata 0. Load 0x10 → rdata 0xDEADBEEF, resp_valid one cycle after acceptance.
- Byte enables: word 0x20 = 0x11223344, then store wdata 0xAABBCCDD, be 0101 → load returns 0x11BB33DD. Store with be 0000 → word unchanged.
- LATENCY=3 with backpressure:
  - Load accepted at T → resp_valid rises exactly at T+3.
  - Hold resp_ready=0 for 5 cycles → outputs stable, req_ready=0, busy=1.
  - resp_ready=1 → req_ready=1 the following cycle.
- Out of range, DEPTH_WORDS=1024: load addr 0x1000 → err 1, rdata 0. Store to 0x1000 → err 1, and a load of word 0 is unchanged.
- Reset mid-operation, LATENCY=3: accept a store of 0x55 at word 4, assert rst at T+1 → resp_valid never rises. After reset, load word 4 → 0x00000055. Request presented alongside rst → not accepted.
- Back-to-back: req_valid held high with 8 alternating store/load requests, resp_ready=1 → exactly one accept per LATENCY+1 cycles and every load matches the prior store.
